// File: rtl/bcd_formatter.sv
// bcd_formatter: serial double-dabble binary-to-BCD converter with sign handling,
// significant-digit count and valid/ready handshakes on both sides.
module bcd_formatter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_DIGITS = 5
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DATA_WIDTH-1:0]               i_data,
   input  logic                                i_is_signed,
   input  logic                                i_valid,
   output logic                                o_ready,
   output logic [4*NUM_DIGITS-1:0]             o_data,
   output logic                                o_data_is_neg,
   output logic [$clog2(NUM_DIGITS+1)-1:0]     o_num_digits,
   output logic                                o_valid,
   input  logic                                i_ready
);
   localparam int CW  = $clog2(DATA_WIDTH + 1);
   localparam int NDW = $clog2(NUM_DIGITS + 1);
   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
   state_t                  state;
   logic [DATA_WIDTH-1:0]   mag, nxt_mag;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] adj, nxt_bcd;
   logic [NDW-1:0]          nxt_digits;
   logic                    in_neg;
   assign in_neg = i_is_signed & i_data[DATA_WIDTH-1];
   // o_data doubles as the BCD accumulator; digit count is taken from the final shift result
   always_comb begin
      adj = o_data;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      {nxt_bcd, nxt_mag} = {adj, mag} << 1;
      nxt_digits = NDW'(1);
      for (int i = 1; i < NUM_DIGITS; i++)
         if (nxt_bcd[4*i +: 4] != 4'd0) nxt_digits = NDW'(i + 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         o_ready       <= 1'b1;
         o_valid       <= 1'b0;
         o_data        <= '0;
         o_data_is_neg <= 1'b0;
         o_num_digits  <= NDW'(1);
         mag           <= '0;
         cnt           <= '0;
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               state         <= CONVERT;
               o_ready       <= 1'b0;
               o_data_is_neg <= in_neg;
               mag           <= in_neg ? ~i_data + 1'b1 : i_data;
               o_data        <= '0;
               cnt           <= '0;
            end
            CONVERT: begin
               o_data <= nxt_bcd;
               mag    <= nxt_mag;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(DATA_WIDTH - 1)) begin
                  state        <= DONE;
                  o_valid      <= 1'b1;
                  o_num_digits <= nxt_digits;
               end
            end
            DONE: if (i_ready) begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_formatter.sv
// tb_bcd_formatter: scoreboard bench; stimulus pushes decimal-arithmetic expectations,
// an independent monitor pops and compares on every output transfer.
module tb_bcd_formatter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] i_data = '0;
   logic        i_is_signed = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [19:0] o_data;
   logic        o_data_is_neg;
   logic [2:0]  o_num_digits;
   logic        o_valid;
   logic        i_ready = 1'b0;
   typedef struct {logic [19:0] bcd; logic neg; logic [2:0] nd;} exp_t;
   exp_t q[$];
   int checks = 0, fails = 0, pushes = 0, outs = 0;
   bcd_formatter dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_is_signed(i_is_signed), .i_valid(i_valid),
      .o_ready(o_ready), .o_data(o_data), .o_data_is_neg(o_data_is_neg),
      .o_num_digits(o_num_digits), .o_valid(o_valid), .i_ready(i_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference: signed interpretation then decimal digits by repeated division
   function automatic exp_t model(input logic [15:0] d, input logic s);
      exp_t e;
      int unsigned v;
      e.neg = s && d[15];
      v = e.neg ? 32'd65536 - 32'(d) : 32'(d);
      e.bcd = '0;
      e.nd = 3'd1;
      for (int i = 0; i < 5; i++) begin
         e.bcd[4*i +: 4] = 4'(v % 10);
         if (v % 10 != 0) e.nd = 3'(i + 1);
         v = v / 10;
      end
      return e;
   endfunction
   task automatic push(input logic [15:0] d, input logic s);
      q.push_back(model(d, s));
      pushes++;
   endtask
   // Monitor: a transfer happens on the next edge when o_valid && i_ready
   initial forever begin
      @(negedge clk);
      #1;
      if (!rst && o_valid && i_ready) begin
         outs++;
         if (q.size() == 0) chk("unexpected_output", 32'(q.size()), 32'd1);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", 32'(o_data), 32'(e.bcd));
            chk("out_neg", 32'(o_data_is_neg), 32'(e.neg));
            chk("out_digits", 32'(o_num_digits), 32'(e.nd));
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic wait_ready();
      for (int k = 0; k < 60 && !o_ready; k++) @(negedge clk);
      chk("wait_ready", 32'(o_ready), 32'd1);
   endtask
   task automatic send(input logic [15:0] d, input logic s);
      int n;
      wait_ready();
      i_data = d; i_is_signed = s; i_valid = 1'b1;
      push(d, s);
      @(negedge clk);
      i_valid = 1'b0;
      n = 1;
      while (!o_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency_edges", 32'(n), 32'd17);
   endtask
   initial begin
      int n, acc, cyc;
      bit seen;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", 32'(o_data), 32'h0);
      chk("rst_neg", 32'(o_data_is_neg), 32'd0);
      chk("rst_digits", 32'(o_num_digits), 32'd1);
      i_ready = 1'b1;
      send(16'hFFFF, 1'b0);
      send(16'h8000, 1'b1);
      send(16'hFFFF, 1'b1);
      send(16'h0000, 1'b1);
      send(16'h0009, 1'b0);
      send(16'h2710, 1'b0);
      // Backpressure with spurious i_valid pulses in CONVERT and DONE
      wait_ready();
      i_ready = 1'b0;
      i_data = 16'h007B; i_is_signed = 1'b1; i_valid = 1'b1;
      push(16'h007B, 1'b1);
      @(negedge clk);
      i_data = 16'h1111;
      n = 0;
      while (!o_valid && n < 40) begin
         i_valid = ~i_valid;
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 10; k++) begin
         i_valid = k[0];
         chk("bp_valid", 32'(o_valid), 32'd1);
         chk("bp_data", 32'(o_data), 32'h00123);
         chk("bp_neg", 32'(o_data_is_neg), 32'd0);
         chk("bp_digits", 32'(o_num_digits), 32'd3);
         chk("bp_ready", 32'(o_ready), 32'd0);
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_after", 32'(o_ready), 32'd1);
      chk("bp_valid_after", 32'(o_valid), 32'd0);
      chk("bp_single_transfer", 32'(q.size()), 32'd0);
      // Reset in the middle of CONVERT discards the word
      i_data = 16'h1234; i_is_signed = 1'b0; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", 32'(o_ready), 32'd1);
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_data", 32'(o_data), 32'h0);
      chk("midrst_digits", 32'(o_num_digits), 32'd1);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);
      send(16'h0400, 1'b0);
      // Random traffic with random handshakes
      @(negedge clk);
      acc = 0;
      cyc = 0;
      while (acc < 100 && cyc < 20000) begin
         n = int'($urandom_range(0, 7));
         i_data = n == 0 ? 16'h8000 : n == 1 ? 16'hFFFF : n == 2 ? 16'h0000 : 16'($urandom);
         i_is_signed = 1'($urandom);
         i_valid = 1'($urandom);
         i_ready = 1'($urandom);
         if (i_valid && o_ready) begin
            push(i_data, i_is_signed);
            acc++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("rand_accepted", 32'(acc), 32'd100);
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 100 && (q.size() != 0 || o_valid); k++) @(negedge clk);
      chk("drain_queue", 32'(q.size()), 32'd0);
      chk("outputs_vs_accepts", 32'(outs), 32'(pushes));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/bcd_formatter.md
BCD_FORMATTER -- requirements
Module: bcd_formatter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the binary result word.
REQ-002 SHALL have parameter NUM_DIGITS, default 5: number of BCD digits produced; legal only if 10^NUM_DIGITS > 2^DATA_WIDTH - 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_data  input  DATA_WIDTH  binary result from the ALU stage.
REQ-006 SHALL have port i_is_signed  input  1  interprets i_data as two's complement when high.
REQ-007 SHALL have port i_valid  input  1  upstream word valid.
REQ-008 SHALL have port o_ready  output  1  block can accept a word.
REQ-009 SHALL have port o_data  output  4*NUM_DIGITS  packed BCD magnitude, digit 0 in bits [3:0].
REQ-010 SHALL have port o_data_is_neg  output  1  value is negative; feeds output_driver i_data_is_neg.
REQ-011 SHALL have port o_num_digits  output  clog2(NUM_DIGITS+1)  count of significant digits, minimum 1.
REQ-012 SHALL have port o_valid  output  1  o_data/o_data_is_neg/o_num_digits valid.
REQ-013 SHALL have port i_ready  input  1  downstream (output_driver) accepts.

Function
REQ-014 SHALL implement an FSM with states IDLE, CONVERT, DONE.
REQ-015 SHALL drive o_ready high only in IDLE and o_valid high only in DONE.
REQ-016 IDLE->CONVERT SHALL occur on the edge where i_valid && o_ready; at that edge capture neg = i_is_signed & i_data[DATA_WIDTH-1] and magnitude = neg ? (~i_data + 1) : i_data, computed unsigned in DATA_WIDTH bits (0x8000 -> 32768), and clear the BCD accumulator and iteration counter.
REQ-017 CONVERT SHALL perform exactly one double-dabble iteration per cycle: every BCD digit >= 5 gets +3, then {BCD, magnitude} shifts left by one bit.
REQ-018 CONVERT->DONE SHALL occur on the edge completing iteration DATA_WIDTH; o_valid first goes high DATA_WIDTH+1 edges after the accepting edge (17 for default).
REQ-019 i_valid and i_data SHALL be ignored outside IDLE; no word is dropped or double-accepted.
REQ-020 In DONE, all outputs SHALL stay stable while i_ready is low, indefinitely.
REQ-021 DONE->IDLE SHALL occur on the edge where o_valid && i_ready; o_ready is high the following cycle; no acceptance on that same edge.
REQ-022 o_num_digits SHALL equal the index of the most significant nonzero digit plus 1, or 1 when the value is zero; computed before or at DONE entry and registered.
REQ-023 Zero input SHALL yield o_data_is_neg = 0 regardless of i_is_signed.
REQ-024 With i_is_signed low, i_data SHALL be treated as unsigned (0xFFFF -> 65535, not negative).
REQ-025 o_data, o_data_is_neg, o_num_digits SHALL be registered outputs; values outside DONE are don't-care to downstream but SHALL NOT contain X after reset.

Reset
REQ-026 On any clock edge with rst high, state SHALL become IDLE irrespective of current state, including mid-CONVERT and in DONE with i_ready low; any in-flight word is discarded.
REQ-027 In the cycle after reset: o_ready = 1, o_valid = 0, o_data = 0, o_data_is_neg = 0, o_num_digits = 1, iteration counter = 0.
REQ-028 rst high SHALL override a simultaneous i_valid && o_ready or o_valid && i_ready handshake.

Verification
REQ-029 Reset: rst high 2 cycles then low -> o_ready = 1, o_valid = 0, o_data = 0x00000, o_num_digits = 1.
REQ-030 Unsigned max: i_data = 0xFFFF, i_is_signed = 0 -> o_valid after exactly 17 edges, o_data = 0x65535, o_data_is_neg = 0, o_num_digits = 5.
REQ-031 Signed extremes: 0x8000 signed -> o_data = 0x32768, neg = 1, digits = 5; 0xFFFF signed -> o_data = 0x00001, neg = 1, digits = 1; 0x0000 signed -> o_data = 0x00000, neg = 0, digits = 1.
REQ-032 Backpressure: result 0x007B signed (123) with i_ready low for 10 cycles after o_valid -> outputs hold 0x00123/0/3, o_ready stays 0, extra i_valid pulses during CONVERT and DONE ignored; i_ready high -> one transfer, o_ready = 1 next cycle.
REQ-033 Reset mid-operation: rst pulsed 1 cycle at iteration 8 of CONVERT -> IDLE next cycle, o_valid never asserts for that word; a subsequent 0x0400 unsigned converts to 0x01024, digits = 4.
REQ-034 Back-to-back: 100 random words with random i_valid/i_ready -> every accepted word produces exactly one output matching a reference model, in order.
